comp_8bit: RTL and testbench

- Registered magnitude comparator for two 8-bit operands.
- Produces one-hot greater/equal/less flags, plus max/min selection and absolute difference.
- Used wherever datapath logic needs an ordered comparison result one clock after the operands are presented.
- Supports unsigned (default) and two's-complement signed comparison, selected per transaction.

---
 rtl/comp_8bit.sv | 80 ++++++++
 tb/tb_comp_8bit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/comp_8bit.sv
// Registered magnitude comparator: one-hot G/E/L plus MAX, MIN and |A-B|, unsigned or signed per operand pair.
// Latency: one cycle from an in_valid edge to out_valid; results hold while in_valid is low.
// Backpressure: none; accepts one operand pair per cycle.
module comp_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    input  logic             signed_mode,
    output logic             G,
    output logic             E,
    output logic             L,
    output logic             out_valid,
    output logic [WIDTH-1:0] MAX,
    output logic [WIDTH-1:0] MIN,
    output logic [WIDTH-1:0] DIFF
);

    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;
    logic             gt_c;
    logic             eq_c;
    logic             decided;
    logic [WIDTH-1:0] max_c;
    logic [WIDTH-1:0] min_c;
    logic [WIDTH-1:0] diff_c;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        a_key = A;
        b_key = B;
        a_key[WIDTH-1] = A[WIDTH-1] ^ signed_mode;
        b_key[WIDTH-1] = B[WIDTH-1] ^ signed_mode;
    end

    // MSB-first cascade: the first differing bit decides the ordering.
    always_comb begin
        gt_c    = 1'b0;
        decided = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!decided && (a_key[i] != b_key[i])) begin
                gt_c    = a_key[i];
                decided = 1'b1;
            end
        end
        eq_c = (A == B);
    end

    always_comb begin
        max_c  = (gt_c || eq_c) ? A : B;
        min_c  = (gt_c || eq_c) ? B : A;
        diff_c = max_c - min_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            G         <= 1'b0;
            E         <= 1'b0;
            L         <= 1'b0;
            out_valid <= 1'b0;
            MAX       <= '0;
            MIN       <= '0;
            DIFF      <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                G    <= gt_c;
                E    <= eq_c;
                L    <= !gt_c && !eq_c;
                MAX  <= max_c;
                MIN  <= min_c;
                DIFF <= diff_c;
            end
        end
    end

endmodule

// File: tb/tb_comp_8bit.sv
// Scoreboarded bench for comp_8bit using directed vectors with hand-computed results.
module tb_comp_8bit;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic       in_valid;
    logic       signed_mode;
    logic       G;
    logic       E;
    logic       L;
    logic       out_valid;
    logic [7:0] MAX;
    logic [7:0] MIN;
    logic [7:0] DIFF;

    typedef struct {
        int         id;
        logic       g;
        logic       e;
        logic       l;
        logic [7:0] mx;
        logic [7:0] mn;
        logic [7:0] df;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   vec_id = 0;

    comp_8bit #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .A(A),
        .B(B),
        .in_valid(in_valid),
        .signed_mode(signed_mode),
        .G(G),
        .E(E),
        .L(L),
        .out_valid(out_valid),
        .MAX(MAX),
        .MIN(MIN),
        .DIFF(DIFF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every presented result is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t x;
        if (out_valid === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: got G=%b E=%b L=%b MAX=%h MIN=%h DIFF=%h, required no result",
                         G, E, L, MAX, MIN, DIFF);
            end else begin
                x = exp_q.pop_front();
                if ({G, E, L, MAX, MIN, DIFF} !== {x.g, x.e, x.l, x.mx, x.mn, x.df}) begin
                    fails++;
                    $display("FAIL vec%0d: got G=%b E=%b L=%b MAX=%h MIN=%h DIFF=%h, required G=%b E=%b L=%b MAX=%h MIN=%h DIFF=%h",
                             x.id, G, E, L, MAX, MIN, DIFF, x.g, x.e, x.l, x.mx, x.mn, x.df);
                end
            end
        end
    end

    // Drive one valid operand pair (ending 1ns after its capture edge) and queue its expected result.
    task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic sm,
                         input logic g, input logic e, input logic l,
                         input logic [7:0] mx, input logic [7:0] mn, input logic [7:0] df);
        exp_t x;
        A           = a;
        B           = b;
        signed_mode = sm;
        in_valid    = 1'b1;
        x.id = vec_id; x.g = g; x.e = e; x.l = l; x.mx = mx; x.mn = mn; x.df = df;
        exp_q.push_back(x);
        vec_id++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string nm, input logic ov, input logic g, input logic e,
                               input logic l, input logic [7:0] mx, input logic [7:0] mn,
                               input logic [7:0] df);
        tests++;
        if ({out_valid, G, E, L, MAX, MIN, DIFF} !== {ov, g, e, l, mx, mn, df}) begin
            fails++;
            $display("FAIL %s: got V=%b G=%b E=%b L=%b MAX=%h MIN=%h DIFF=%h, required V=%b G=%b E=%b L=%b MAX=%h MIN=%h DIFF=%h",
                     nm, out_valid, G, E, L, MAX, MIN, DIFF, ov, g, e, l, mx, mn, df);
        end
    endtask

    initial begin
        rst         = 1'b1;
        A           = 8'h00;
        B           = 8'h00;
        in_valid    = 1'b0;
        signed_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        rst = 1'b0;

        // Equality, unsigned (and one signed case: equality ignores mode)
        apply(8'h00, 8'h00, 1'b0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
        apply(8'hFF, 8'hFF, 1'b0, 0, 1, 0, 8'hFF, 8'hFF, 8'h00);
        apply(8'hA5, 8'hA5, 1'b0, 0, 1, 0, 8'hA5, 8'hA5, 8'h00);
        apply(8'h80, 8'h80, 1'b1, 0, 1, 0, 8'h80, 8'h80, 8'h00);
        // A > B unsigned
        apply(8'h01, 8'h00, 1'b0, 1, 0, 0, 8'h01, 8'h00, 8'h01);
        apply(8'h10, 8'h0F, 1'b0, 1, 0, 0, 8'h10, 8'h0F, 8'h01);
        apply(8'hF1, 8'hF0, 1'b0, 1, 0, 0, 8'hF1, 8'hF0, 8'h01);
        // A < B unsigned
        apply(8'h00, 8'h01, 1'b0, 0, 0, 1, 8'h01, 8'h00, 8'h01);
        apply(8'h0F, 8'h10, 1'b0, 0, 0, 1, 8'h10, 8'h0F, 8'h01);
        apply(8'hF0, 8'hF1, 1'b0, 0, 0, 1, 8'hF1, 8'hF0, 8'h01);
        // Sign boundary, unsigned then signed
        apply(8'h80, 8'h7F, 1'b0, 1, 0, 0, 8'h80, 8'h7F, 8'h01);
        apply(8'h80, 8'h7F, 1'b1, 0, 0, 1, 8'h7F, 8'h80, 8'hFF);
        apply(8'h7F, 8'h80, 1'b0, 0, 0, 1, 8'h80, 8'h7F, 8'h01);
        apply(8'h7F, 8'h80, 1'b1, 1, 0, 0, 8'h7F, 8'h80, 8'hFF);
        apply(8'hFF, 8'h00, 1'b0, 1, 0, 0, 8'hFF, 8'h00, 8'hFF);
        apply(8'hFF, 8'h00, 1'b1, 0, 0, 1, 8'h00, 8'hFF, 8'h01);
        apply(8'h00, 8'hFF, 1'b0, 0, 0, 1, 8'hFF, 8'h00, 8'hFF);
        apply(8'h00, 8'hFF, 1'b1, 1, 0, 0, 8'h00, 8'hFF, 8'h01);

        // Valid gating: two idle cycles hold the last result with out_valid low
        apply(8'h05, 8'h03, 1'b0, 1, 0, 0, 8'h05, 8'h03, 8'h02);
        idle_cycle();
        check_state("gap_hold_1", 1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h03, 8'h02);
        idle_cycle();
        check_state("gap_hold_2", 1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h03, 8'h02);
        apply(8'h03, 8'h05, 1'b0, 0, 0, 1, 8'h05, 8'h03, 8'h02);
        check_state("gap_resume", 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 8'h03, 8'h02);

        // Reset after a completed result clears everything
        apply(8'h01, 8'h00, 1'b0, 1, 0, 0, 8'h01, 8'h00, 8'h01);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        check_state("rst_mid_clear", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        // Reset wins over an in-flight valid 01h/00h: no G pulse may appear
        A        = 8'h01;
        B        = 8'h00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_state("rst_priority", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_state("rst_no_pulse", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
